// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-step radix-2 multiply/divide FSM; define MULDIV_FAST_MUL_EN for a single-cycle multiply
package selector;
  typedef enum logic [2:0] {
    MULDIV_MULT,
    MULDIV_MULTU,
    MULDIV_DIV,
    MULDIV_DIVU,
    MULDIV_NCARE
  } muldiv_funct_t;
endpackage

module muldiv_unit
  import selector::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          flush,
  input  muldiv_funct_t muldiv_funct,
  input  logic [31:0]   a,
  input  logic [31:0]   b,
  output logic          busy,
  output logic          done,
  output logic [31:0]   hi,
  output logic [31:0]   lo
);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t        state_q;
  muldiv_funct_t funct_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic [63:0]   acc_q, acc_d;
  logic [4:0]    cnt_q;
  logic          done_q;
  logic          in_signed, is_signed, is_mul, neg, fast_go, ge;
  logic [31:0]   a_in_mag, b_mag, div_rem, quo, rem, res_hi, res_lo;
  logic [32:0]   add_sum, div_sh;
  logic [63:0]   prod;

  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // operation decode and operand magnitudes for the signed ops
  always_comb begin
    in_signed = muldiv_funct == MULDIV_MULT || muldiv_funct == MULDIV_DIV;
    is_signed = funct_q == MULDIV_MULT || funct_q == MULDIV_DIV;
    is_mul    = funct_q == MULDIV_MULT || funct_q == MULDIV_MULTU;
    a_in_mag  = in_signed && a[31] ? -a : a;
    b_mag     = is_signed && b_q[31] ? -b_q : b_q;
    neg       = is_signed && (a_q[31] ^ b_q[31]);
  end

  // one radix-2 iteration: shift-add multiply, restoring shift-subtract divide
  always_comb begin
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag} : 33'd0);
    div_sh  = {acc_q[63:32], acc_q[31]};
    ge      = div_sh >= {1'b0, b_mag};
    div_rem = div_sh[31:0] - b_mag;
    acc_d   = is_mul ? {add_sum, acc_q[31:1]}
            : ge     ? {div_rem, acc_q[30:0], 1'b1}
            :          {div_sh[31:0], acc_q[30:0], 1'b0};
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_go = muldiv_funct == MULDIV_MULT || muldiv_funct == MULDIV_MULTU;
  assign prod    = is_signed ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q}
                             : {32'd0, a_q} * {32'd0, b_q};
`else
  assign fast_go = 1'b0;
  assign prod    = neg ? -acc_q : acc_q;
`endif

  // sign correction and divide-by-zero override applied in FINISH
  always_comb begin
    quo    = acc_q[31:0];
    rem    = acc_q[63:32];
    res_lo = is_mul ? prod[31:0]  : b_q == 32'd0 ? 32'hFFFF_FFFF : neg ? -quo : quo;
    res_hi = is_mul ? prod[63:32] : b_q == 32'd0 ? a_q : is_signed && a_q[31] ? -rem : rem;
  end

  // control FSM with registered done and hi/lo; flush always returns to IDLE
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      funct_q <= MULDIV_NCARE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) state_q <= IDLE;
      else
        case (state_q)
          IDLE:
            if (start && muldiv_funct != MULDIV_NCARE) begin
              funct_q <= muldiv_funct;
              a_q     <= a;
              b_q     <= b;
              acc_q   <= {32'd0, a_in_mag};
              cnt_q   <= 5'd31;
              state_q <= fast_go ? FINISH : CALC;
            end
          CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_q <= FINISH;
          end
          FINISH: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table plus scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  import selector::*;

  typedef struct { muldiv_funct_t f; logic [31:0] a, b, hi, lo; } vec_t;
  typedef struct { logic [31:0] hi, lo; } exp_t;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, flush = 1'b0;
  muldiv_funct_t muldiv_funct = MULDIV_NCARE;
  logic [31:0]   a = '0, b = '0;
  logic          busy, done;
  logic [31:0]   hi, lo;

  exp_t          sb[$];
  exp_t          mon_e, re;
  vec_t          vecs[14];
  int            n_checks = 0, n_fail = 0;
  logic [31:0]   last_hi = '0, last_lo = '0, rx, ry;
  muldiv_funct_t rf;

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .muldiv_funct(muldiv_funct), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        mon_e = sb.pop_front();
        check("result_hi", 64'(hi), 64'(mon_e.hi));
        check("result_lo", 64'(lo), 64'(mon_e.lo));
      end
    end

  function automatic int lat_of(muldiv_funct_t f);
`ifdef MULDIV_FAST_MUL_EN
    return (f == MULDIV_MULT || f == MULDIV_MULTU) ? 1 : 33;
`else
    return (f == MULDIV_NCARE) ? 0 : 33;
`endif
  endfunction

  function automatic exp_t model(muldiv_funct_t f, logic [31:0] x, logic [31:0] y);
    exp_t r;
    logic [63:0] p;
    r = '{32'd0, 32'd0};
    if (f == MULDIV_MULT) begin
      p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      r = '{p[63:32], p[31:0]};
    end else if (f == MULDIV_MULTU) begin
      p = {32'd0, x} * {32'd0, y};
      r = '{p[63:32], p[31:0]};
    end else if (y == 32'd0) r = '{x, 32'hFFFF_FFFF};
    else if (f == MULDIV_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '{32'd0, 32'h8000_0000};
    else if (f == MULDIV_DIV) begin
      r.lo = $signed(x) / $signed(y);
      r.hi = $signed(x) % $signed(y);
    end else begin
      r.lo = x / y;
      r.hi = x % y;
    end
    return r;
  endfunction

  task automatic issue(muldiv_funct_t f, logic [31:0] x, logic [31:0] y);
    @(negedge clk);
    muldiv_funct = f;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(int lat);
    int n;
    for (n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check("latency", 64'(n), 64'(lat));
  endtask

  task automatic run(muldiv_funct_t f, logic [31:0] x, logic [31:0] y, logic [31:0] eh, logic [31:0] el);
    issue(f, x, y);
    sb.push_back('{eh, el});
    last_hi = eh;
    last_lo = el;
    check("busy_after_start", 64'(busy), 64'd1);
    wait_done(lat_of(f));
  endtask

  task automatic check_idle_unchanged(string nm);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_hi"}, 64'(hi), 64'(last_hi));
    check({nm, "_lo"}, 64'(lo), 64'(last_lo));
  endtask

  initial begin
    vecs[0]  = '{MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{MULDIV_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{MULDIV_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{MULDIV_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[4]  = '{MULDIV_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5]  = '{MULDIV_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6]  = '{MULDIV_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};
    vecs[7]  = '{MULDIV_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[8]  = '{MULDIV_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{MULDIV_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{MULDIV_MULT,  32'h0000_3039, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7};
    vecs[11] = '{MULDIV_DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF};
    vecs[12] = '{MULDIV_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE};
    vecs[13] = '{MULDIV_DIVU,  32'd9,         32'd2,         32'd1,         32'd4};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    for (int i = 0; i < 10; i++) begin
      rf = muldiv_funct_t'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i % 3 == 0) ry = ry >> 20;
      re = model(rf, rx, ry);
      run(rf, rx, ry, re.hi, re.lo);
    end

    issue(MULDIV_NCARE, 32'd5, 32'd6);
    check_idle_unchanged("ncare");
    repeat (40) @(posedge clk);

    issue(MULDIV_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check_idle_unchanged("flush_calc");
    repeat (3) @(posedge clk);
    run(MULDIV_DIVU, 32'd9, 32'd2, 32'd1, 32'd4);

    @(negedge clk);
    muldiv_funct = MULDIV_DIVU;
    a = 32'd50;
    b = 32'd5;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    flush = 1'b0;
    check_idle_unchanged("flush_start");

    issue(MULDIV_DIVU, 32'd1000, 32'd3);
    sb.push_back('{32'd1, 32'd333});
    last_hi = 32'd1;
    last_lo = 32'd333;
    @(negedge clk);
    muldiv_funct = MULDIV_MULTU;
    a = 32'd6;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(32);
    repeat (40) @(posedge clk);
    #1 check_idle_unchanged("start_busy");

    issue(MULDIV_DIVU, 32'd50, 32'd5);
    repeat (32) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_fin_done", 64'(done), 64'd0);
    check_idle_unchanged("flush_fin");
    repeat (5) @(posedge clk);

    issue(MULDIV_DIVU, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (40) @(posedge clk);
    run(MULDIV_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Clock and reset SHALL be: clk input 1, single clock, all state on rising edge; reset_n input 1, asynchronous, active-low.
REQ-002 Input start, 1 bit, SHALL request an operation when high.
REQ-003 Input flush, 1 bit, SHALL request cancellation of the current operation when high.
REQ-004 Input muldiv_funct SHALL be of type selector::muldiv_funct_t and take one of MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU or MULDIV_NCARE.
REQ-005 Input a, 32 bits, SHALL be operand A, taken from $rs.
REQ-006 Input b, 32 bits, SHALL be operand B, taken from $rt.
REQ-007 Output busy, 1 bit, SHALL be high while an operation is in flight.
REQ-008 Output done, 1 bit, SHALL be a one-cycle pulse marking hi/lo valid.
REQ-009 Output hi, 32 bits, SHALL carry the product upper word or the remainder.
REQ-010 Output lo, 32 bits, SHALL carry the product lower word or the quotient.

Function
REQ-011 The state machine SHALL have states IDLE, CALC and FINISH.
REQ-012 In IDLE with start=1, flush=0 and funct not NCARE, the block SHALL latch funct, a and b, load the iteration counter with 31, and enter CALC.
REQ-013 In IDLE, start with funct=NCARE SHALL be ignored: state stays IDLE and no done is produced.
REQ-014 busy SHALL be high in CALC and FINISH, and low in IDLE.
REQ-015 start SHALL be ignored while busy=1; no queueing is performed.
REQ-016 In CALC, one radix-2 step SHALL run per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 In CALC, the counter SHALL decrement each cycle, and CALC SHALL exit to FINISH after the step at counter=0, giving 32 steps.
REQ-018 Signed ops (MULT, DIV) SHALL iterate on magnitudes; sign correction SHALL be applied in FINISH.
REQ-019 MULT sign correction: the 64-bit product SHALL be negated if a[31]^b[31].
REQ-020 DIV sign correction: the quotient SHALL be negated if a[31]^b[31], and the remainder SHALL take the sign of a.
REQ-021 In FINISH, hi/lo SHALL be registered from the corrected result, done=1 for that cycle, and the next state SHALL be IDLE.
REQ-022 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+33, and busy SHALL fall with done.
REQ-023 hi/lo SHALL hold their value from the last done until the next done, and SHALL be unaffected by any aborted operation.
REQ-024 Multiply SHALL be computed as a 32x32 to 64 multiply; all arithmetic SHALL be modulo 2^64 or 2^32 as appropriate.
REQ-025 Divide by zero, signed or unsigned, SHALL give lo=32'hFFFFFFFF and hi=a, and SHALL NOT raise an exception.
REQ-026 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-027 flush=1 in any state SHALL force the next state to IDLE and suppress done; hi/lo SHALL stay unchanged.
REQ-028 If flush=1 and start=1 occur in the same IDLE cycle, flush SHALL win and no operation SHALL start.
REQ-029 If flush=1 in FINISH, the block SHALL suppress both the done pulse and the hi/lo update.

Reset
REQ-030 On reset_n low, the block SHALL enter IDLE asynchronously, with busy=0, done=0, hi=0, lo=0, counter=0, and internal accumulators cleared.
REQ-031 Reset asserted mid-operation SHALL abandon the operation without producing done.
REQ-032 The first start after reset_n rises SHALL be accepted normally.

Configuration
REQ-033 Macro MULDIV_FAST_MUL_EN SHALL select the multiply path at compile time.
REQ-034 With MULDIV_FAST_MUL_EN defined, MULT/MULTU SHALL skip CALC: IDLE goes to FINISH, with the full product formed combinationally from the latched operands, and done SHALL rise in the cycle after edge k+1.
REQ-035 With MULDIV_FAST_MUL_EN defined, DIV/DIVU SHALL remain iterative.
REQ-036 Without MULDIV_FAST_MUL_EN, all four ops SHALL use the 32-step iterative path of REQ-022.

Verification
REQ-037 MULTU with a=32'hFFFFFFFF, b=32'hFFFFFFFF SHALL give hi=32'hFFFFFFFE, lo=32'h00000001, done at k+33, or at k+1 with MULDIV_FAST_MUL_EN.
REQ-038 MULT with a=-3, b=7 SHALL give hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-039 DIV with a=-7, b=2 SHALL give lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); DIVU with a=7, b=0 SHALL give lo=32'hFFFFFFFF, hi=7.
REQ-040 DIVU with a=100, b=7 started, flush pulsed at k+10, then DIVU with a=9, b=2 started: there SHALL be no done for the first op, and the second SHALL return lo=4, hi=1.
REQ-041 A second start while busy SHALL be ignored, with result matching the first op only; reset_n dropped at k+5 SHALL give busy=0, hi=lo=0, and no done.
